pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage 64-bit-PC pipeline. It drives PC_Write, IF_ID_Write, the IF/ID and ID/EX flushes, the ID/EX control bubble, and a global pipeline hold. It handles three events: load-use stalls, taken-branch flushes (multi-cycle, to cover fetch latency) and data-memory wait freezes with timeout detection. It sits beside the decode stage and feeds the IF_ID_Write input of the IF/ID register directly.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed per taken branch (1..15)
MAX_WAIT, 16, freeze cycles after which timeout_err is set (1..255)

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
ID_rs1  input  5  rs1 field of the instruction in ID
ID_rs2  input  5  rs2 field of the instruction in ID
ID_uses_rs1  input  1  ID instruction reads rs1
ID_uses_rs2  input  1  ID instruction reads rs2
ID_EX_rd  input  5  destination register in EX
ID_EX_MemRead  input  1  EX instruction is a load
branch_taken  input  1  EX resolved a taken branch or jump this cycle
mem_req  input  1  MEM stage is accessing data memory
mem_ready  input  1  data memory completes the access this cycle
PC_Write  output  1  PC register load enable
IF_ID_Write  output  1  IF/ID load enable (0 holds)
IF_ID_Flush  output  1  clear IF/ID to NOP
ID_EX_Flush  output  1  clear ID/EX to NOP
ID_EX_Bubble  output  1  zero ID/EX control fields (load-use bubble)
pipe_hold  output  1  freeze all pipeline registers (EX/MEM, MEM/WB included)
timeout_err  output  1  sticky flag: memory wait reached MAX_WAIT
stall_cnt  output  32  performance counter, see Optional Feature
flush_cnt  output  32  performance counter, see Optional Feature

Behaviour:
- Clock is clk only. reset is synchronous and active-high. Every register updates only on posedge clk.
- Registered state: state {RUN, FLUSH, FREEZE}, flush_left[3:0], wait_cnt[7:0], resume_flush (1 bit), timeout_err.
- On reset: state=RUN, flush_left=0, wait_cnt=0, resume_flush=0, timeout_err=0, counters=0.
- Outputs are combinational from the current state and inputs. Values while reset=1: PC_Write=1, IF_ID_Write=1, all flushes, bubble and hold=0.
- Definition of mem_stall: mem_req & ~mem_ready.
- Definition of load_use: ID_EX_MemRead & (ID_EX_rd!=0) & ((ID_uses_rs1 & ID_rs1==ID_EX_rd) | (ID_uses_rs2 & ID_rs2==ID_EX_rd)).
- Priority within a cycle: reset > mem_stall > branch_taken > load_use.
- RUN:
  - mem_stall: pipe_hold=1, PC_Write=0, IF_ID_Write=0. Go to FREEZE with wait_cnt=1 and resume_flush=0.
  - branch_taken: PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. If FLUSH_CYCLES>1, go to FLUSH with flush_left=FLUSH_CYCLES-1.
  - load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. Stay in RUN. The stall is naturally one cycle because the bubble clears ID_EX_MemRead.
  - none of the above: PC_Write=1, IF_ID_Write=1.
- FLUSH:
  - IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1. branch_taken and load_use are ignored because EX holds bubbles.
  - flush_left decrements each cycle; go to RUN when it reaches 0.
  - mem_stall has priority: outputs as in the RUN freeze case, flush_left holds, resume_flush=1, go to FREEZE.
- FREEZE:
  - While mem_stall: pipe_hold=1, PC_Write=0, IF_ID_Write=0, flushes=0. wait_cnt increments, saturating at 255.
  - When wait_cnt==MAX_WAIT with mem_stall still high, timeout_err is set. It stays set until reset; the block remains in FREEZE.
  - Release cycle (mem_stall=0): pipe_hold=0, wait_cnt=0.
    - If resume_flush=1: FLUSH outputs apply and the block returns to FLUSH.
    - Otherwise the cycle is evaluated exactly as a RUN cycle, so a held branch_taken or load_use is acted on in this cycle.
- Reset mid-FREEZE or mid-FLUSH: the next state is RUN, and pending flushes are dropped.
- IF_ID_Flush and IF_ID_Write may both be 1: the flush wins in the IF/ID register.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments (wrapping) on every cycle with IF_ID_Write=0 and reset=0. flush_cnt increments on every cycle with IF_ID_Flush=1.
- Not defined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_rd=5, ID_rs1=5, ID_uses_rs1=1 -> exactly 1 cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. With rd=0 -> no stall.
- Branch, FLUSH_CYCLES=2: branch_taken pulse -> IF_ID_Flush=1 for 2 cycles, ID_EX_Flush=1 only in the first, PC_Write=1 in both.
- Freeze: mem_req=1, mem_ready=0 for 4 cycles -> pipe_hold=1 for 4 cycles. On the cycle mem_ready=1 -> pipe_hold=0, and the state is RUN the next cycle.
- Freeze with a branch held in EX: branch_taken=1 throughout a 3-cycle freeze -> no flush during the freeze, IF_ID_Flush=1 in the release cycle.
- Timeout, MAX_WAIT=16: mem_ready held at 0 -> timeout_err rises after the 16th freeze cycle, stays 1 after mem_ready=1, and clears only on reset.
- Reset during FLUSH (FLUSH_CYCLES=4, reset on the 2nd cycle) -> all flushes 0 the next cycle. With HAZARD_PERF_CNT_EN, stall_cnt and flush_cnt read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, multi-cycle branch flushes, data-memory freezes.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_MemRead,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        ID_EX_Bubble,
    output logic        pipe_hold,
    output logic        timeout_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, FREEZE} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [3:0] flush_left, flush_left_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       resume_flush, resume_flush_nxt;
    logic       timeout_nxt;

    logic mem_stall;
    logic load_use;
    logic run_like;
    logic flush_like;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                       ((ID_uses_rs1 & (ID_rs1 == ID_EX_rd)) |
                        (ID_uses_rs2 & (ID_rs2 == ID_EX_rd)));

    always_comb begin
        PC_Write         = 1'b1;
        IF_ID_Write      = 1'b1;
        IF_ID_Flush      = 1'b0;
        ID_EX_Flush      = 1'b0;
        ID_EX_Bubble     = 1'b0;
        pipe_hold        = 1'b0;
        state_nxt        = state;
        flush_left_nxt   = flush_left;
        wait_cnt_nxt     = wait_cnt;
        resume_flush_nxt = resume_flush;
        timeout_nxt      = timeout_err;
        run_like         = 1'b0;
        flush_like       = 1'b0;

        if (!reset) begin
            case (state)
                RUN: run_like = 1'b1;
                FLUSH: begin
                    if (mem_stall) begin
                        pipe_hold        = 1'b1;
                        PC_Write         = 1'b0;
                        IF_ID_Write      = 1'b0;
                        state_nxt        = FREEZE;
                        wait_cnt_nxt     = 8'd1;
                        resume_flush_nxt = 1'b1;
                    end else begin
                        flush_like = 1'b1;
                    end
                end
                FREEZE: begin
                    if (mem_stall) begin
                        pipe_hold    = 1'b1;
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LIMIT)
                            timeout_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt     = 8'd0;
                        resume_flush_nxt = 1'b0;
                        if (resume_flush)
                            flush_like = 1'b1;
                        else
                            run_like = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase

            if (run_like) begin
                if (mem_stall) begin
                    pipe_hold        = 1'b1;
                    PC_Write         = 1'b0;
                    IF_ID_Write      = 1'b0;
                    state_nxt        = FREEZE;
                    wait_cnt_nxt     = 8'd1;
                    resume_flush_nxt = 1'b0;
                end else if (branch_taken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt      = FLUSH;
                        flush_left_nxt = FLUSH_INIT;
                    end else begin
                        state_nxt = RUN;
                    end
                end else if (load_use) begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    state_nxt    = RUN;
                end else begin
                    state_nxt = RUN;
                end
            end

            // A release cycle after a stalled flush stands in for the flush cycle that was held off.
            if (flush_like) begin
                IF_ID_Flush = 1'b1;
                if (flush_left > 4'd1) begin
                    state_nxt      = FLUSH;
                    flush_left_nxt = flush_left - 4'd1;
                end else begin
                    state_nxt      = RUN;
                    flush_left_nxt = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            flush_left   <= 4'd0;
            wait_cnt     <= 8'd0;
            resume_flush <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            flush_left   <= flush_left_nxt;
            wait_cnt     <= wait_cnt_nxt;
            resume_flush <= resume_flush_nxt;
            timeout_err  <= timeout_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!IF_ID_Write)
                stall_cnt <= stall_cnt + 32'd1;
            if (IF_ID_Flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; two instances (FLUSH_CYCLES=2 and 4) share stimulus.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs1, rs2, ex_rd;
    logic       uses_rs1, uses_rs2, ex_memread;
    logic       branch_taken, mem_req, mem_ready;

    logic pcw2, ifw2, iff2, idf2, bub2, hold2, to2;
    logic pcw4, ifw4, iff4, idf4, bub4, hold4, to4;
    logic [31:0] sc2, fc2, sc4, fc4;
    logic [6:0] obs2, obs4;

    assign obs2 = {pcw2, ifw2, iff2, idf2, bub2, hold2, to2};
    assign obs4 = {pcw4, ifw4, iff4, idf4, bub4, hold4, to4};

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_WAIT(16)) u2 (
        .clk(clk), .reset(reset),
        .ID_rs1(rs1), .ID_rs2(rs2), .ID_uses_rs1(uses_rs1), .ID_uses_rs2(uses_rs2),
        .ID_EX_rd(ex_rd), .ID_EX_MemRead(ex_memread), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_Write(pcw2), .IF_ID_Write(ifw2), .IF_ID_Flush(iff2), .ID_EX_Flush(idf2),
        .ID_EX_Bubble(bub2), .pipe_hold(hold2), .timeout_err(to2),
        .stall_cnt(sc2), .flush_cnt(fc2)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(4), .MAX_WAIT(16)) u4 (
        .clk(clk), .reset(reset),
        .ID_rs1(rs1), .ID_rs2(rs2), .ID_uses_rs1(uses_rs1), .ID_uses_rs2(uses_rs2),
        .ID_EX_rd(ex_rd), .ID_EX_MemRead(ex_memread), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_Write(pcw4), .IF_ID_Write(ifw4), .IF_ID_Flush(iff4), .ID_EX_Flush(idf4),
        .ID_EX_Bubble(bub4), .pipe_hold(hold4), .timeout_err(to4),
        .stall_cnt(sc4), .flush_cnt(fc4)
    );

    // Output vector order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Bubble, pipe_hold, timeout_err
    localparam logic [6:0] O_RUN = 7'b1100000;
    localparam logic [6:0] O_BR  = 7'b1111000;
    localparam logic [6:0] O_FL  = 7'b1110000;
    localparam logic [6:0] O_LU  = 7'b0000100;
    localparam logic [6:0] O_FZ  = 7'b0000010;
    localparam logic [6:0] O_TO  = 7'b0000001;

    typedef struct packed { logic [6:0] e2; logic [6:0] e4; } exp_t;
    typedef struct packed { logic lu; logic br; logic [1:0] mem; logic [6:0] e2; logic [6:0] e4; } step_t;

    exp_t sb[$];
    int n_vec  = 0;
    int n_miss = 0;

    // mem: 0 idle, 1 stalled access, 2 access completing this cycle
    task automatic drive(input logic lu, input logic br, input logic [1:0] mem);
        ex_memread   = lu;
        ex_rd        = lu ? 5'd5 : 5'd0;
        rs1          = 5'd5;
        uses_rs1     = 1'b1;
        rs2          = 5'd7;
        uses_rs2     = 1'b1;
        branch_taken = br;
        mem_req      = (mem != 2'd0);
        mem_ready    = (mem == 2'd2);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'd1);
        sb.push_back('{O_RUN, O_RUN});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (obs2 !== e.e2 || obs4 !== e.e4) begin
            n_miss++;
            $display("FAIL reset_active: got u2=%b u4=%b, want u2=%b u4=%b", obs2, obs4, e.e2, e.e4);
        end
        n_vec++;
        if (sc2 !== 32'd0 || fc2 !== 32'd0 || sc4 !== 32'd0 || fc4 !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d, want all 0", sc2, fc2, sc4, fc4);
        end
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0);
        sb.push_back('{O_RUN, O_RUN});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (obs2 !== e.e2 || obs4 !== e.e4) begin
            n_miss++;
            $display("FAIL reset_release: got u2=%b u4=%b, want u2=%b u4=%b", obs2, obs4, e.e2, e.e4);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        typedef struct packed {
            logic mr; logic [4:0] rd; logic [4:0] r1; logic u1; logic [4:0] r2; logic u2; logic [6:0] ex;
        } lu_t;
        lu_t  t[$];
        exp_t e;
        t.push_back('{1'b1, 5'd5,  5'd5,  1'b1, 5'd0, 1'b0, O_LU});
        t.push_back('{1'b0, 5'd5,  5'd5,  1'b1, 5'd0, 1'b0, O_RUN});
        t.push_back('{1'b1, 5'd0,  5'd0,  1'b1, 5'd0, 1'b1, O_RUN});
        t.push_back('{1'b1, 5'd9,  5'd3,  1'b1, 5'd9, 1'b1, O_LU});
        t.push_back('{1'b0, 5'd9,  5'd3,  1'b1, 5'd9, 1'b1, O_RUN});
        t.push_back('{1'b1, 5'd9,  5'd9,  1'b0, 5'd9, 1'b0, O_RUN});
        t.push_back('{1'b1, 5'd31, 5'd31, 1'b1, 5'd0, 1'b0, O_LU});
        t.push_back('{1'b1, 5'd12, 5'd11, 1'b1, 5'd13, 1'b1, O_RUN});
        foreach (t[i]) begin
            drive(1'b0, 1'b0, 2'd0);
            ex_memread = t[i].mr;
            ex_rd      = t[i].rd;
            rs1        = t[i].r1;
            uses_rs1   = t[i].u1;
            rs2        = t[i].r2;
            uses_rs2   = t[i].u2;
            sb.push_back('{t[i].ex, t[i].ex});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL load_use step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        step_t s[$];
        exp_t  e;
        s.push_back('{1'b0, 1'b1, 2'd0, O_BR,  O_BR});
        s.push_back('{1'b1, 1'b1, 2'd0, O_FL,  O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_RUN});
        foreach (s[i]) begin
            drive(s[i].lu, s[i].br, s[i].mem);
            sb.push_back('{s[i].e2, s[i].e4});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL branch step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t  e;
        s.push_back('{1'b1, 1'b0, 2'd0, O_LU,  O_LU});
        s.push_back('{1'b0, 1'b1, 2'd0, O_BR,  O_BR});
        s.push_back('{1'b0, 1'b0, 2'd0, O_FL,  O_FL});
        s.push_back('{1'b1, 1'b0, 2'd0, O_LU,  O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_RUN});
        s.push_back('{1'b1, 1'b1, 2'd1, O_FZ,  O_FZ});
        s.push_back('{1'b1, 1'b1, 2'd2, O_BR,  O_BR});
        s.push_back('{1'b0, 1'b0, 2'd0, O_FL,  O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_RUN});
        foreach (s[i]) begin
            drive(s[i].lu, s[i].br, s[i].mem);
            sb.push_back('{s[i].e2, s[i].e4});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL back_to_back step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            next_cycle();
        end
    endtask

    task automatic test_freeze();
        step_t s[$];
        exp_t  e;
        for (int k = 0; k < 4; k++)
            s.push_back('{1'b0, 1'b0, 2'd1, O_FZ, O_FZ});
        s.push_back('{1'b0, 1'b0, 2'd2, O_RUN, O_RUN});
        s.push_back('{1'b1, 1'b0, 2'd0, O_LU,  O_LU});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_RUN});
        foreach (s[i]) begin
            drive(s[i].lu, s[i].br, s[i].mem);
            sb.push_back('{s[i].e2, s[i].e4});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL freeze step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            next_cycle();
        end
    endtask

    task automatic test_freeze_branch();
        step_t s[$];
        exp_t  e;
        for (int k = 0; k < 3; k++)
            s.push_back('{1'b0, 1'b1, 2'd1, O_FZ, O_FZ});
        s.push_back('{1'b0, 1'b1, 2'd2, O_BR,  O_BR});
        s.push_back('{1'b0, 1'b0, 2'd0, O_FL,  O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_RUN});
        foreach (s[i]) begin
            drive(s[i].lu, s[i].br, s[i].mem);
            sb.push_back('{s[i].e2, s[i].e4});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL freeze_branch step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_freeze();
        step_t s[$];
        exp_t  e;
        s.push_back('{1'b0, 1'b1, 2'd0, O_BR,  O_BR});
        s.push_back('{1'b0, 1'b0, 2'd1, O_FZ,  O_FZ});
        s.push_back('{1'b0, 1'b1, 2'd1, O_FZ,  O_FZ});
        s.push_back('{1'b0, 1'b0, 2'd0, O_FL,  O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_FL});
        s.push_back('{1'b0, 1'b0, 2'd0, O_RUN, O_RUN});
        foreach (s[i]) begin
            drive(s[i].lu, s[i].br, s[i].mem);
            sb.push_back('{s[i].e2, s[i].e4});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL flush_freeze step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        exp_t       e;
        logic [6:0] x;
        // Cycle 0 enters the freeze (wait_cnt=1); the flag is raised in the cycle where wait_cnt==16.
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, 1'b0, (i < 20) ? 2'd1 : ((i == 20) ? 2'd2 : 2'd0));
            x = ((i < 20) ? O_FZ : O_RUN) | ((i >= 17) ? O_TO : 7'd0);
            sb.push_back('{x, x});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL timeout step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            next_cycle();
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd0);
        next_cycle();
        reset = 1'b0;
        sb.push_back('{O_RUN, O_RUN});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (obs2 !== e.e2 || obs4 !== e.e4) begin
            n_miss++;
            $display("FAIL timeout_clear: got u2=%b u4=%b, want u2=%b u4=%b", obs2, obs4, e.e2, e.e4);
        end
        next_cycle();
    endtask

    task automatic test_reset_flush();
        exp_t e;
        drive(1'b0, 1'b1, 2'd0);
        sb.push_back('{O_BR, O_BR});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (obs2 !== e.e2 || obs4 !== e.e4) begin
            n_miss++;
            $display("FAIL reset_flush_branch: got u2=%b u4=%b, want u2=%b u4=%b", obs2, obs4, e.e2, e.e4);
        end
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd0);
        sb.push_back('{O_RUN, O_RUN});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (obs2 !== e.e2 || obs4 !== e.e4) begin
            n_miss++;
            $display("FAIL reset_flush_during: got u2=%b u4=%b, want u2=%b u4=%b", obs2, obs4, e.e2, e.e4);
        end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{O_RUN, O_RUN});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e.e2 || obs4 !== e.e4) begin
                n_miss++;
                $display("FAIL reset_flush_after step %0d: got u2=%b u4=%b, want u2=%b u4=%b", i, obs2, obs4, e.e2, e.e4);
            end
            if (i == 0) begin
                n_vec++;
                if (sc2 !== 32'd0 || fc2 !== 32'd0 || sc4 !== 32'd0 || fc4 !== 32'd0) begin
                    n_miss++;
                    $display("FAIL reset_flush_counters: got %0d %0d %0d %0d, want all 0", sc2, fc2, sc4, fc4);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd0);
        next_cycle();
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_freeze();
        test_freeze_branch();
        test_flush_freeze();
        test_timeout();
        test_reset_flush();
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
